fmap_pool_reader: RTL and testbench

//  Reads the flat binary-conv feature-map bus produced by the layer-1 conv block (10 ch x 24x24 x bW).

---
 rtl/conv_pkg.sv | 22 ++
 rtl/fmap_pool_reader_pool_max4.sv | 24 ++
 rtl/fmap_pool_reader.sv | 168 ++++++++++++++++
 tb/tb_fmap_pool_reader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the layer-1 feature-map pooling path.
//   BW_DEF / CH_DEF / IN_DIM_DEF : default element width, channel count, input map size
//   OUT_DIM_DEF                  : pooled map size (IN_DIM_DEF / 2)
//   CH_W / DIM_W                 : counter widths for channel and pooled row/column
//   fsm_e                        : reader FSM states
package conv_pkg;

    localparam int unsigned BW_DEF      = 8;
    localparam int unsigned CH_DEF      = 10;
    localparam int unsigned IN_DIM_DEF  = 24;
    localparam int unsigned OUT_DIM_DEF = IN_DIM_DEF / 2;

    localparam int unsigned CH_W  = $clog2(CH_DEF);
    localparam int unsigned DIM_W = $clog2(OUT_DIM_DEF);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FIN    = 2'd2
    } fsm_e;

endpackage

// File: rtl/fmap_pool_reader_pool_max4.sv
// Combinational unsigned maximum of four bW-bit values (one 2x2 pooling window).
//   a_i, b_i, c_i, d_i : window elements
//   max_o              : largest of the four (ties resolve to any equal value)
module pool_max4 #(
    parameter int unsigned bW = 8
) (
    input  logic [bW-1:0] a_i,
    input  logic [bW-1:0] b_i,
    input  logic [bW-1:0] c_i,
    input  logic [bW-1:0] d_i,
    output logic [bW-1:0] max_o
);

    logic [bW-1:0] max_ab;
    logic [bW-1:0] max_cd;

    // Two-level compare tree
    always_comb begin
        max_ab = (a_i > b_i) ? a_i : b_i;
        max_cd = (c_i > d_i) ? c_i : d_i;
        max_o  = (max_ab > max_cd) ? max_ab : max_cd;
    end

endmodule

// File: rtl/fmap_pool_reader.sv
// Streams the 2x2/stride-2 max-pool of a flat CH x IN_DIM x IN_DIM feature map over valid/ready.
//   clk, rst        : clock, asynchronous active-high reset
//   fmap_i          : flat map, element (c,r,x) at ((c*IN_DIM+r)*IN_DIM+x)*bW, lowest index = MSB
//   start_i         : pulse in IDLE to begin a pass
//   busy_o, done_o  : pass in progress / one-cycle completion pulse
//   out_valid/ready : output handshake
//   out_data        : pooled value; out_chan/out_row/out_col its position; out_last on the final one
module fmap_pool_reader
    import conv_pkg::*;
#(
    parameter int unsigned bW     = BW_DEF,
    parameter int unsigned CH     = CH_DEF,
    parameter int unsigned IN_DIM = IN_DIM_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [0:CH*IN_DIM*IN_DIM*bW-1] fmap_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [bW-1:0]                 out_data,
    output logic [$clog2(CH)-1:0]         out_chan,
    output logic [$clog2(IN_DIM/2)-1:0]   out_row,
    output logic [$clog2(IN_DIM/2)-1:0]   out_col,
    output logic                          out_last,
    output logic                          done_o
);

    localparam int unsigned OUT_DIM = IN_DIM / 2;
    localparam int unsigned N_BITS  = CH * IN_DIM * IN_DIM * bW;
    localparam int unsigned CW      = $clog2(CH);
    localparam int unsigned DW      = $clog2(OUT_DIM);
    localparam int unsigned IW      = $clog2(N_BITS);

    fsm_e          state_q, state_d;
    logic          load_c, first_c, valid_d, busy_d, done_d;
    logic          hs_c;
    logic [CW-1:0] nxt_chan_c;
    logic [DW-1:0] nxt_row_c, nxt_col_c;
    logic          nxt_last_c;
    logic [31:0]   base_c;
    logic [IW-1:0] idx00_c, idx01_c, idx10_c, idx11_c;
    logic [bW-1:0] max_c;

    assign hs_c = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = S_STREAM;
            S_STREAM: if (hs_c && out_last) state_d = S_FIN;
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output/control decode; the start cycle already loads element (0,0,0) for latency 1
    always_comb begin
        load_c  = 1'b0;
        first_c = 1'b0;
        valid_d = out_valid;
        busy_d  = busy_o;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start_i) begin
                    load_c  = 1'b1;
                    first_c = 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_STREAM: begin
                busy_d = 1'b1;
                if (hs_c && out_last) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if ((!out_valid || out_ready) && !out_last) begin
                    load_c  = 1'b1;
                    valid_d = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Scan counters: column innermost, then row, channel outermost
    always_comb begin
        nxt_chan_c = out_chan;
        nxt_row_c  = out_row;
        nxt_col_c  = out_col;
        if (first_c) begin
            nxt_chan_c = '0;
            nxt_row_c  = '0;
            nxt_col_c  = '0;
        end else if (out_col == DW'(OUT_DIM - 1)) begin
            nxt_col_c = '0;
            if (out_row == DW'(OUT_DIM - 1)) begin
                nxt_row_c  = '0;
                nxt_chan_c = out_chan + 1'b1;
            end else begin
                nxt_row_c = out_row + 1'b1;
            end
        end else begin
            nxt_col_c = out_col + 1'b1;
        end
        nxt_last_c = (nxt_chan_c == CW'(CH - 1)) && (nxt_row_c == DW'(OUT_DIM - 1))
                     && (nxt_col_c == DW'(OUT_DIM - 1));
    end

    // Bit offsets of the four window elements of the next output
    always_comb begin
        base_c  = ((32'(nxt_chan_c) * IN_DIM + 32'(nxt_row_c) * 32'd2) * IN_DIM
                   + 32'(nxt_col_c) * 32'd2) * bW;
        idx00_c = IW'(base_c);
        idx01_c = IW'(base_c + bW);
        idx10_c = IW'(base_c + IN_DIM * bW);
        idx11_c = IW'(base_c + IN_DIM * bW + bW);
    end

    pool_max4 #(.bW(bW)) u_max (
        .a_i   (fmap_i[idx00_c +: bW]),
        .b_i   (fmap_i[idx01_c +: bW]),
        .c_i   (fmap_i[idx10_c +: bW]),
        .d_i   (fmap_i[idx11_c +: bW]),
        .max_o (max_c)
    );

    // Output register; holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= valid_d;
            busy_o    <= busy_d;
            done_o    <= done_d;
            if (load_c) begin
                out_data <= max_c;
                out_chan <= nxt_chan_c;
                out_row  <= nxt_row_c;
                out_col  <= nxt_col_c;
                out_last <= nxt_last_c;
            end
        end
    end

endmodule

// File: tb/tb_fmap_pool_reader.sv
// Randomised self-checking bench for fmap_pool_reader against a scan-order max-pool model.
module tb_fmap_pool_reader;
    import conv_pkg::*;

    localparam int unsigned BW    = BW_DEF;
    localparam int unsigned NCH   = CH_DEF;
    localparam int unsigned IN    = IN_DIM_DEF;
    localparam int unsigned OD    = OUT_DIM_DEF;
    localparam int unsigned NBITS = NCH * IN * IN * BW;
    localparam int          NBEAT = NCH * OD * OD;

    logic              clk = 1'b0;
    logic              rst;
    logic [0:NBITS-1]  fmap;
    logic              start_i, busy_o, out_valid, out_ready, out_last, done_o;
    logic [BW-1:0]     out_data;
    logic [CH_W-1:0]   out_chan;
    logic [DIM_W-1:0]  out_row, out_col;

    fmap_pool_reader dut (
        .clk(clk), .rst(rst), .fmap_i(fmap), .start_i(start_i), .busy_o(busy_o),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_chan(out_chan), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int c;
        int r;
        int x;
        bit l;
    } beat_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          img[NCH][IN][IN];
    int          exp_q[$];
    beat_t       beats[$];
    int          done_cnt, done_cyc, stall_err, extra_beats;
    bit          timed_out, busy_first, valid_first;
    logic [31:0] rst_snap;

    // Reference: plain 2x2 max over the image array, in scan order
    function automatic void build_expected();
        exp_q.delete();
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < OD; r++)
                for (int x = 0; x < OD; x++) begin
                    int m = 0;
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++)
                            if (img[c][2*r+dy][2*x+dx] > m) m = img[c][2*r+dy][2*x+dx];
                    exp_q.push_back(m);
                end
    endfunction

    task automatic pack_image();
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < IN; r++)
                for (int x = 0; x < IN; x++)
                    fmap[((c*IN + r)*IN + x)*BW +: BW] = BW'(img[c][r][x]);
        build_expected();
    endtask

    // Drives one pass and records handshakes; options: ready %, start at beat, start in FIN, reset at beat
    task automatic run_pass(input int pct, input int start_at, input bit start_fin, input int rst_at);
        int    cyc;
        bit    stalled, sent;
        beat_t prev, cur;
        beats.delete();
        done_cnt = 0; done_cyc = -1; stall_err = 0; extra_beats = 0; timed_out = 0;
        stalled = 0; sent = 0; rst_snap = '1;
        out_ready = ($urandom_range(0, 99) < pct);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        busy_first  = busy_o;
        valid_first = out_valid;
        cyc = 0;
        forever begin
            start_i = 1'b0;
            if (rst_at >= 0 && beats.size() == rst_at) begin
                rst = 1'b1;
                #1;
                rst_snap = {out_valid, busy_o, done_o, out_last, 4'd0, out_data,
                            4'(out_chan), 4'(out_row), 4'(out_col)};
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
                repeat (6) begin
                    @(posedge clk); #1;
                    if (done_o) done_cnt++;
                    if (out_valid) extra_beats++;
                end
                break;
            end
            cur.d = int'(out_data); cur.c = int'(out_chan); cur.r = int'(out_row);
            cur.x = int'(out_col);  cur.l = out_last;
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                if (start_fin) start_i = 1'b1;
            end
            if (stalled && (!out_valid || cur.d != prev.d || cur.c != prev.c ||
                            cur.r != prev.r || cur.x != prev.x || cur.l != prev.l))
                stall_err++;
            if (out_valid && done_cnt > 0) extra_beats++;
            if (start_at >= 0 && !sent && beats.size() == start_at) begin
                start_i = 1'b1;
                sent = 1;
            end
            out_ready = ($urandom_range(0, 99) < pct);
            if (out_valid && out_ready) beats.push_back(cur);
            stalled = out_valid && !out_ready;
            prev = cur;
            if (done_cyc >= 0 && cyc >= done_cyc + 6) break;
            if (cyc > 20000) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; out_ready = 1'b0; fmap = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, busy_o, done_o} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_idle cycle %0d: valid/busy/done=%b required 000", i,
                         {out_valid, busy_o, done_o});
            end
        end
    endtask

    task automatic test_full_pass();
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < IN; r++)
                for (int x = 0; x < IN; x++) img[c][r][x] = (c + r + x) % 256;
        pack_image();
        run_pass(100, -1, 0, -1);
        n_cmp++;
        if (timed_out) begin n_bad++; $display("FAIL full_timeout: no done_o"); end
        n_cmp++;
        if (beats.size() != NBEAT) begin
            n_bad++; $display("FAIL full_count: %0d beats required %0d", beats.size(), NBEAT);
        end
        for (int i = 0; i < beats.size() && i < NBEAT; i++) begin
            n_cmp++;
            if (beats[i].d != exp_q[i] || beats[i].c != i / (OD*OD) || beats[i].r != (i / OD) % OD ||
                beats[i].x != i % OD || beats[i].l != (i == NBEAT - 1)) begin
                n_bad++;
                $display("FAIL full_beat %0d: got d=%0d (%0d,%0d,%0d) last=%0d required d=%0d (%0d,%0d,%0d) last=%0d",
                         i, beats[i].d, beats[i].c, beats[i].r, beats[i].x, beats[i].l, exp_q[i],
                         i / (OD*OD), (i / OD) % OD, i % OD, i == NBEAT - 1);
            end
        end
        if (beats.size() == NBEAT) begin
            n_cmp++;
            if (beats[0].d != 2) begin n_bad++; $display("FAIL full_first: %0d required 2", beats[0].d); end
            n_cmp++;
            if (beats[NBEAT-1].d != 55) begin
                n_bad++; $display("FAIL full_lastdata: %0d required 55", beats[NBEAT-1].d);
            end
        end
        n_cmp++;
        if (!valid_first || !busy_first) begin
            n_bad++; $display("FAIL full_latency: valid=%0d busy=%0d required 1 1", valid_first, busy_first);
        end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL full_done_count: %0d required 1", done_cnt); end
        n_cmp++;
        if (done_cyc != NBEAT) begin
            n_bad++; $display("FAIL full_done_time: %0d cycles after start edge required %0d", done_cyc, NBEAT);
        end
    endtask

    task automatic test_single_hot();
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < IN; r++)
                for (int x = 0; x < IN; x++) img[c][r][x] = 0;
        img[3][5][7] = 255;
        pack_image();
        run_pass(100, -1, 0, -1);
        n_cmp++;
        if (timed_out || beats.size() != NBEAT) begin
            n_bad++; $display("FAIL hot_count: %0d beats timeout=%0d required %0d", beats.size(), timed_out, NBEAT);
        end
        for (int i = 0; i < beats.size() && i < NBEAT; i++) begin
            n_cmp++;
            if (beats[i].d != exp_q[i]) begin
                n_bad++; $display("FAIL hot_beat %0d: %0d required %0d", i, beats[i].d, exp_q[i]);
            end
        end
        if (beats.size() == NBEAT) begin
            n_cmp++;
            if (beats[3*OD*OD + 2*OD + 3].d != 255) begin
                n_bad++; $display("FAIL hot_pos: %0d required 255", beats[3*OD*OD + 2*OD + 3].d);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < IN; r++)
                for (int x = 0; x < IN; x++) img[c][r][x] = $urandom_range(0, 255);
        pack_image();
        run_pass(50, -1, 0, -1);
        n_cmp++;
        if (timed_out || beats.size() != NBEAT) begin
            n_bad++; $display("FAIL bp_count: %0d beats timeout=%0d required %0d", beats.size(), timed_out, NBEAT);
        end
        for (int i = 0; i < beats.size() && i < NBEAT; i++) begin
            n_cmp++;
            if (beats[i].d != exp_q[i] || beats[i].c != i / (OD*OD) || beats[i].r != (i / OD) % OD ||
                beats[i].x != i % OD || beats[i].l != (i == NBEAT - 1)) begin
                n_bad++;
                $display("FAIL bp_beat %0d: got d=%0d (%0d,%0d,%0d) required d=%0d", i, beats[i].d,
                         beats[i].c, beats[i].r, beats[i].x, exp_q[i]);
            end
        end
        n_cmp++;
        if (stall_err != 0) begin n_bad++; $display("FAIL bp_stable: %0d changes while stalled required 0", stall_err); end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL bp_done: %0d required 1", done_cnt); end
    endtask

    task automatic test_start_ignored();
        run_pass(100, 100, 1, -1);
        n_cmp++;
        if (timed_out || beats.size() != NBEAT) begin
            n_bad++; $display("FAIL restart_count: %0d beats timeout=%0d required %0d", beats.size(), timed_out, NBEAT);
        end
        for (int i = 0; i < beats.size() && i < NBEAT; i++) begin
            n_cmp++;
            if (beats[i].d != exp_q[i] || beats[i].c != i / (OD*OD) || beats[i].r != (i / OD) % OD ||
                beats[i].x != i % OD) begin
                n_bad++; $display("FAIL restart_beat %0d: got d=%0d required %0d", i, beats[i].d, exp_q[i]);
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL restart_done: %0d required 1", done_cnt); end
        n_cmp++;
        if (extra_beats != 0) begin n_bad++; $display("FAIL restart_extra: %0d valid after done required 0", extra_beats); end
        n_cmp++;
        if (done_cyc != NBEAT) begin n_bad++; $display("FAIL restart_time: %0d required %0d", done_cyc, NBEAT); end
    endtask

    task automatic test_reset_mid_pass();
        run_pass(100, -1, 0, 700);
        n_cmp++;
        if (rst_snap !== 32'd0) begin n_bad++; $display("FAIL midrst_outputs: %h required 0", rst_snap); end
        n_cmp++;
        if (done_cnt != 0 || extra_beats != 0) begin
            n_bad++; $display("FAIL midrst_quiet: done=%0d valid=%0d required 0 0", done_cnt, extra_beats);
        end
        n_cmp++;
        if (beats.size() != 700) begin n_bad++; $display("FAIL midrst_beats: %0d required 700", beats.size()); end
        run_pass(100, -1, 0, -1);
        n_cmp++;
        if (timed_out || beats.size() != NBEAT || done_cnt != 1) begin
            n_bad++; $display("FAIL midrst_rerun: %0d beats done=%0d required %0d 1", beats.size(), done_cnt, NBEAT);
        end
        for (int i = 0; i < beats.size() && i < NBEAT; i++) begin
            n_cmp++;
            if (beats[i].d != exp_q[i] || beats[i].c != i / (OD*OD) || beats[i].r != (i / OD) % OD ||
                beats[i].x != i % OD || beats[i].l != (i == NBEAT - 1)) begin
                n_bad++; $display("FAIL midrst_beat %0d: got d=%0d required %0d", i, beats[i].d, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_single_hot();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_pass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
